// File: rtl/paillier_l_pkg.sv
// Shared constants, state type and borrow helper for the L-function feeder.
package paillier_l_pkg;

   localparam int N       = 4096;
   localparam int M       = 2048;
   localparam int Block   = 128;
   localparam int Ncnt    = N / Block;
   localparam int Mcnt    = M / Block;
   localparam int CNT_W   = $clog2(Ncnt) + 1;
   localparam int ADDR_W  = $clog2(Ncnt);
   localparam int NADDR_W = $clog2(Mcnt);

   localparam logic [CNT_W-1:0]  CNT_ZERO      = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0]  LAST_BEAT     = CNT_W'(Ncnt - 1);
   localparam logic [CNT_W-1:0]  STREAM_END    = CNT_W'(Ncnt);
   localparam logic [ADDR_W-1:0] DIVISOR_BEATS = ADDR_W'(Mcnt);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      START  = 3'd2,
      STREAM = 3'd3,
      WAIT   = 3'd4
   } l_feed_state_t;

   // One block of the serial subtract: the borrow only ever moves by one.
   function automatic logic [Block-1:0] sub_borrow(input logic [Block-1:0] v, input logic b);
      return v - {{(Block-1){1'b0}}, b};
   endfunction

endpackage

// File: rtl/l_sub_one_feeder_if.sv
// Input beat channel and divider-facing stream of the L-function feeder.
interface l_sub_one_feeder_if;
   import paillier_l_pkg::*;

   logic [Block-1:0] x_in;
   logic [Block-1:0] n_in;
   logic             in_vld;
   logic             in_rdy;
   logic             div_valid;
   logic             div_data_vld;
   logic [Block-1:0] div_dividend;
   logic [Block-1:0] div_divisor;
   logic             div_done;

   modport master (
      output x_in, n_in, in_vld, div_done,
      input  in_rdy, div_valid, div_data_vld, div_dividend, div_divisor
   );

   modport slave (
      input  x_in, n_in, in_vld, div_done,
      output in_rdy, div_valid, div_data_vld, div_dividend, div_divisor
   );

endinterface

// File: rtl/l_feed_buf.sv
// Operand buffer: one write port, one read port with registered, zero-when-idle read data.
module l_feed_buf
   import paillier_l_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [Block-1:0]  wr_dividend,
   input  logic [Block-1:0]  wr_divisor,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [Block-1:0]  rd_dividend,
   output logic [Block-1:0]  rd_divisor
);

   logic [Block-1:0] mem_d [Ncnt];
   logic [Block-1:0] mem_n [Mcnt];

   // Storage writes; divisor beats past Mcnt-1 are dropped.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_d[wr_addr] <= wr_dividend;
         if (wr_addr < DIVISOR_BEATS) begin
            mem_n[wr_addr[NADDR_W-1:0]] <= wr_divisor;
         end
      end
   end

   // Registered read; divisor reads zero on the upper beats.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_dividend <= {Block{1'b0}};
         rd_divisor  <= {Block{1'b0}};
      end else if (rd_en) begin
         rd_dividend <= mem_d[rd_addr];
         if (rd_addr < DIVISOR_BEATS) begin
            rd_divisor <= mem_n[rd_addr[NADDR_W-1:0]];
         end else begin
            rd_divisor <= {Block{1'b0}};
         end
      end else begin
         rd_dividend <= {Block{1'b0}};
         rd_divisor  <= {Block{1'b0}};
      end
   end

endmodule

// File: rtl/l_sub_one_feeder.sv
// Feeder for L(x) = (x-1)/n: buffers x-1 and n, then streams them to the divider.
// Build option L_FEED_UNDERFLOW_CHK_EN: flag x==0 as underflow and skip the stream.
module l_sub_one_feeder
   import paillier_l_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   l_sub_one_feeder_if.slave   bus,
   output logic                busy,
   output logic                underflow
);

   l_feed_state_t     state_r, state_next;
   logic [CNT_W-1:0]  cnt_r, cnt_next;
   logic              borrow_r, borrow_next;
   logic              borrow_in, borrow_out;
   logic              in_rdy_r, div_valid_r, div_data_vld_r, busy_r, underflow_r;
   logic              underflow_set, underflow_clr;
   logic              xfer;
   logic              wr_en, rd_en;
   logic [ADDR_W-1:0] wr_addr, rd_addr;
   logic [Block-1:0]  wr_dividend;
   logic [Block-1:0]  rd_dividend, rd_divisor;

   assign xfer = bus.in_vld && in_rdy_r;

   // Next state, counter, borrow chain and buffer port control.
   always_comb begin
      state_next    = state_r;
      cnt_next      = cnt_r;
      borrow_next   = borrow_r;
      wr_en         = 1'b0;
      wr_addr       = cnt_r[ADDR_W-1:0];
      rd_en         = 1'b0;
      rd_addr       = cnt_r[ADDR_W-1:0];
      underflow_set = 1'b0;
      underflow_clr = 1'b0;
      if (state_r == IDLE) begin
         borrow_in = 1'b1;
      end else begin
         borrow_in = borrow_r;
      end
      wr_dividend = sub_borrow(bus.x_in, borrow_in);
      borrow_out  = borrow_in && (bus.x_in == {Block{1'b0}});

      case (state_r)
         IDLE: begin
            if (xfer) begin
               wr_en         = 1'b1;
               wr_addr       = {ADDR_W{1'b0}};
               cnt_next      = CNT_ONE;
               borrow_next   = borrow_out;
               underflow_clr = 1'b1;
               state_next    = LOAD;
            end else begin
               state_next = IDLE;
            end
         end
         LOAD: begin
            if (xfer) begin
               wr_en = 1'b1;
               if (cnt_r == LAST_BEAT) begin
                  cnt_next    = CNT_ZERO;
                  borrow_next = 1'b0;
`ifdef L_FEED_UNDERFLOW_CHK_EN
                  if (borrow_out) begin
                     underflow_set = 1'b1;
                     state_next    = IDLE;
                  end else begin
                     state_next = START;
                  end
`else
                  state_next = START;
`endif
               end else begin
                  cnt_next    = cnt_r + CNT_ONE;
                  borrow_next = borrow_out;
               end
            end else begin
               state_next = LOAD;
            end
         end
         START: begin
            // Beat 0 is read here so it is on the outputs the first STREAM cycle.
            rd_en      = 1'b1;
            rd_addr    = {ADDR_W{1'b0}};
            cnt_next   = CNT_ONE;
            state_next = STREAM;
         end
         STREAM: begin
            if (cnt_r == STREAM_END) begin
               cnt_next   = CNT_ZERO;
               state_next = WAIT;
            end else begin
               rd_en    = 1'b1;
               cnt_next = cnt_r + CNT_ONE;
            end
         end
         WAIT: begin
            if (bus.div_done) begin
               state_next = IDLE;
            end else begin
               state_next = WAIT;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, counter and registered outputs, all decoded from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r        <= IDLE;
         cnt_r          <= CNT_ZERO;
         borrow_r       <= 1'b0;
         in_rdy_r       <= 1'b0;
         div_valid_r    <= 1'b0;
         div_data_vld_r <= 1'b0;
         busy_r         <= 1'b0;
      end else begin
         state_r        <= state_next;
         cnt_r          <= cnt_next;
         borrow_r       <= borrow_next;
         in_rdy_r       <= (state_next == IDLE) || (state_next == LOAD);
         div_valid_r    <= (state_next == START);
         div_data_vld_r <= (state_next == STREAM);
         busy_r         <= (state_next != IDLE);
      end
   end

   // Sticky underflow, cleared by the next accepted beat 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         underflow_r <= 1'b0;
      end else if (underflow_set) begin
         underflow_r <= 1'b1;
      end else if (underflow_clr) begin
         underflow_r <= 1'b0;
      end else begin
         underflow_r <= underflow_r;
      end
   end

   l_feed_buf u_buf (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_dividend (wr_dividend),
      .wr_divisor  (bus.n_in),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_dividend (rd_dividend),
      .rd_divisor  (rd_divisor)
   );

   assign bus.in_rdy       = in_rdy_r;
   assign bus.div_valid    = div_valid_r;
   assign bus.div_data_vld = div_data_vld_r;
   assign bus.div_dividend = rd_dividend;
   assign bus.div_divisor  = rd_divisor;
   assign busy             = busy_r;
   assign underflow        = underflow_r;

endmodule

// File: tb/tb_l_sub_one_feeder.sv
// Randomized directed bench for l_sub_one_feeder; expected stream is (x-1) and n computed as wide integers.
module tb_l_sub_one_feeder;
   import paillier_l_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic busy;
   logic underflow;
   int   checks = 0;
   int   errors = 0;

   l_sub_one_feeder_if bus ();

   l_sub_one_feeder dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .busy      (busy),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [Block-1:0] obs, input logic [Block-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] rand_wide();
      logic [N-1:0] v;
      for (int j = 0; j < N / 32; j++) v[j*32 +: 32] = $urandom();
      return v;
   endfunction

   function automatic logic [M-1:0] rand_n();
      logic [M-1:0] v;
      for (int j = 0; j < M / 32; j++) v[j*32 +: 32] = $urandom();
      return v;
   endfunction

   // gap: 0 none, 1 every third cycle idle, 2 random idle cycles
   task automatic run_job(input logic [N-1:0] x, input logic [M-1:0] n, input int gap,
                          input bit done_in_load, input int rst_beat);
      logic [N-1:0]     d;
      logic [Block-1:0] exp_div;
      bit               uf;
      bit               idle;
      int               i;
      int               guard;
      d  = x - 1;
      uf = 1'b0;
`ifdef L_FEED_UNDERFLOW_CHK_EN
      uf = (x == '0);
`endif
      i = 0;
      guard = 0;
      while (i < Ncnt && guard < 2000) begin
         @(negedge clk);
         guard++;
         bus.div_done = (done_in_load && guard == 6);
         idle = (gap == 1 && guard % 3 == 0) || (gap == 2 && $urandom_range(0, 2) == 0);
         if (idle) begin
            bus.in_vld = 1'b0;
            bus.x_in   = Block'($urandom());
         end else begin
            bus.in_vld = 1'b1;
            bus.x_in   = x[i*Block +: Block];
            if (i < Mcnt) bus.n_in = n[i*Block +: Block];
            else          bus.n_in = {4{$urandom()}};
         end
         if (bus.in_vld && bus.in_rdy) i++;
      end
      chk("load_complete", 128'(i), 128'(Ncnt));
      @(negedge clk);
      bus.in_vld   = 1'b0;
      bus.div_done = 1'b0;
      if (uf) begin
         chk("uf_flag", 128'(underflow), 128'(1));
         chk("uf_busy", 128'(busy), 128'(0));
         chk("uf_in_rdy", 128'(bus.in_rdy), 128'(1));
         for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("uf_no_start", 128'(bus.div_valid | bus.div_data_vld), 128'(0));
         end
         chk("uf_sticky", 128'(underflow), 128'(1));
         return;
      end
      chk("start_pulse", 128'(bus.div_valid), 128'(1));
      chk("start_no_data", 128'(bus.div_data_vld), 128'(0));
      chk("start_in_rdy", 128'(bus.in_rdy), 128'(0));
      chk("start_busy", 128'(busy), 128'(1));
      chk("no_underflow", 128'(underflow), 128'(0));
      for (int k = 0; k < Ncnt; k++) begin
         @(negedge clk);
         if (k == rst_beat) begin
            rst = 1'b1;
            #1;
            chk("rst_data_vld", 128'(bus.div_data_vld), 128'(0));
            chk("rst_dividend", bus.div_dividend, 128'(0));
            chk("rst_busy", 128'(busy), 128'(0));
            @(negedge clk);
            rst = 1'b0;
            for (int c = 0; c < 40; c++) begin
               @(negedge clk);
               chk("rst_no_resume", 128'(bus.div_data_vld | bus.div_valid | busy), 128'(0));
            end
            return;
         end
         exp_div = (k < Mcnt) ? n[k*Block +: Block] : '0;
         chk($sformatf("vld_b%0d", k), 128'(bus.div_data_vld), 128'(1));
         chk($sformatf("one_pulse_b%0d", k), 128'(bus.div_valid), 128'(0));
         chk($sformatf("dividend_b%0d", k), bus.div_dividend, d[k*Block +: Block]);
         chk($sformatf("divisor_b%0d", k), bus.div_divisor, exp_div);
      end
      @(negedge clk);
      chk("stream_end_vld", 128'(bus.div_data_vld), 128'(0));
      for (int c = 0; c < 4; c++) begin
         bus.in_vld = 1'b1;
         bus.x_in   = Block'($urandom());
         chk("wait_in_rdy", 128'(bus.in_rdy), 128'(0));
         chk("wait_busy", 128'(busy), 128'(1));
         @(negedge clk);
      end
      bus.in_vld   = 1'b0;
      bus.div_done = 1'b1;
      @(negedge clk);
      bus.div_done = 1'b0;
      chk("done_busy", 128'(busy), 128'(0));
      chk("done_in_rdy", 128'(bus.in_rdy), 128'(1));
   endtask

   initial begin
      logic [N-1:0] x;
      logic [M-1:0] n;
      rst          = 1'b1;
      bus.x_in     = '0;
      bus.n_in     = '0;
      bus.in_vld   = 1'b0;
      bus.div_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_in_rdy", 128'(bus.in_rdy), 128'(0));
      chk("reset_div_valid", 128'(bus.div_valid), 128'(0));
      chk("reset_data_vld", 128'(bus.div_data_vld), 128'(0));
      chk("reset_dividend", bus.div_dividend, 128'(0));
      chk("reset_divisor", bus.div_divisor, 128'(0));
      chk("reset_busy", 128'(busy), 128'(0));
      chk("reset_underflow", 128'(underflow), 128'(0));
      rst = 1'b0;

      run_job(N'(5), M'(3), 0, 1'b0, -1);
      x = '0;
      x[Block] = 1'b1;
      run_job(x, rand_n(), 0, 1'b0, -1);
      run_job('0, rand_n(), 0, 1'b0, -1);
      x = rand_wide();
      n = rand_n();
      run_job(x, n, 1, 1'b0, -1);
      run_job(x, n, 0, 1'b0, -1);
      run_job(rand_wide(), rand_n(), 2, 1'b1, -1);
      run_job(rand_wide(), rand_n(), 0, 1'b0, 10);
      x = rand_wide();
      x[4*Block-1:0] = '0;
      run_job(x, rand_n(), 2, 1'b0, -1);
      run_job(rand_wide(), rand_n(), 2, 1'b1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
